// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if: Start/Busy/Done handshake and data bus of the BCD-to-binary converter
interface bcd_to_binary_seq_if #(parameter int NDIG = 3);
    logic                Start;
    logic [4*NDIG-1:0]   Digits;
    logic                Busy;
    logic                Done;
    logic                Err;
    logic [4*NDIG-1:0]   Bin;
    modport master (output Start, Digits, input Busy, Done, Err, Bin);
    modport slave  (input Start, Digits, output Busy, Done, Err, Bin);
endinterface

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: reverse double-dabble BCD-to-binary converter, one shift per clock
module bcd_to_binary_seq #(
    parameter int NDIG = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    bcd_to_binary_seq_if.slave  bus
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(W);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  bcd_q, bcd_d;
    logic [W-1:0]  bin_q, bin_d;
    logic [W-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [2*W-1:0] sh;
    logic [W-1:0]  bcd_sh;
    logic          bad;

    // One datapath step: shift {bcd,bin} right, then pull 3 off any BCD nibble that reached 8
    always_comb begin
        sh     = {bcd_q, bin_q} >> 1;
        bcd_sh = sh[2*W-1:W];
        for (int i = 0; i < NDIG; i++)
            if (bcd_sh[4*i+:4] >= 4'd8) bcd_sh[4*i+:4] = bcd_sh[4*i+:4] - 4'd3;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if (bus.Digits[4*i+:4] > 4'd9) bad = 1'b1;
    end

    // Control: capture in IDLE/DONE, iterate W times in CONV, publish result on the last shift
    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (state_q == CONV) begin
            bcd_d = bcd_sh;
            bin_d = sh[W-1:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                res_d   = sh[W-1:0];
                state_d = DONE;
            end
        end else if (bus.Start) begin
            bcd_d   = bus.Digits;
            bin_d   = '0;
            cnt_d   = '0;
            err_d   = bad;
            res_d   = bad ? '0 : res_q;
            state_d = bad ? DONE : CONV;
        end else begin
            state_d = IDLE;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.Busy = (state_q == CONV);
    assign bus.Done = (state_q == DONE);
    assign bus.Err  = err_q;
    assign bus.Bin  = res_q;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed checks of the BCD-to-binary converter handshake and results
module tb_bcd_to_binary_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    bcd_to_binary_seq_if #(.NDIG(3)) bus ();
    bcd_to_binary_seq #(.NDIG(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input logic [11:0] d);
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.Digits = d;
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.Digits = 12'hFFF;
    endtask

    task automatic wait_done(output int busy_cnt);
        int g = 0;
        busy_cnt = 0;
        while (!bus.Done && g < 100) begin
            busy_cnt += int'(bus.Busy);
            g++;
            @(negedge clk);
        end
        chk("done_seen", 32'(bus.Done), 32'd1);
    endtask

    task automatic run(input string tag, input logic [11:0] d, input logic [11:0] exp_bin,
                       input logic exp_err, input int exp_busy);
        int b;
        start_conv(d);
        wait_done(b);
        chk({tag, "_busy"}, 32'(b), 32'(exp_busy));
        chk({tag, "_bin"}, 32'(bus.Bin), 32'(exp_bin));
        chk({tag, "_err"}, 32'(bus.Err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
        chk({tag, "_bin_hold"}, 32'(bus.Bin), 32'(exp_bin));
    endtask

    initial begin
        bus.Start  = 1'b0;
        bus.Digits = 12'h000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_err", 32'(bus.Err), 32'd0);
        chk("rst_bin", 32'(bus.Bin), 32'd0);
        reset_n = 1'b1;

        run("t1_199", 12'h199, 12'h0C7, 1'b0, 12);
        run("t2_000", 12'h000, 12'h000, 1'b0, 12);
        run("t2_999", 12'h999, 12'h3E7, 1'b0, 12);
        run("t3_1A3", 12'h1A3, 12'h000, 1'b1, 0);
        run("t3_recover", 12'h010, 12'h00A, 1'b0, 12);

        // Start ignored mid-conversion: second request with 999 must not disturb 057
        start_conv(12'h057);
        repeat (3) @(negedge clk);
        bus.Start  = 1'b1;
        bus.Digits = 12'h999;
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.Digits = 12'hFFF;
        wait_done(n);
        chk("t4_busy_rest", 32'(n), 32'd8);
        chk("t4_bin", 32'(bus.Bin), 32'h039);
        chk("t4_err", 32'(bus.Err), 32'd0);

        // Back-to-back: Start while Done is high goes straight into CONV
        bus.Start  = 1'b1;
        bus.Digits = 12'h100;
        @(negedge clk);
        bus.Start  = 1'b0;
        bus.Digits = 12'hFFF;
        chk("t5_no_gap_busy", 32'(bus.Busy), 32'd1);
        chk("t5_done_low", 32'(bus.Done), 32'd0);
        chk("t5_bin_kept", 32'(bus.Bin), 32'h039);
        wait_done(n);
        chk("t5_busy", 32'(n), 32'd12);
        chk("t5_bin", 32'(bus.Bin), 32'h064);

        // Asynchronous reset in the middle of a conversion
        start_conv(12'h999);
        repeat (4) @(negedge clk);
        chk("t6_busy_before", 32'(bus.Busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bus.Busy), 32'd0);
        chk("t6_rst_done", 32'(bus.Done), 32'd0);
        chk("t6_rst_err", 32'(bus.Err), 32'd0);
        chk("t6_rst_bin", 32'(bus.Bin), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run("t6_042", 12'h042, 12'h02A, 1'b0, 12);

        // Adder sweep: sum of two 2-digit BCD numbers re-encoded as BCD, converted back
        for (int a1 = 0; a1 < 10; a1++) begin
            for (int b1 = 0; b1 < 10; b1++) begin
                int a0, b0, s;
                logic [11:0] d;
                a0 = (a1 * 3 + b1) % 10;
                b0 = (b1 * 7 + a1) % 10;
                s  = 10 * a1 + a0 + 10 * b1 + b0;
                d  = {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
                start_conv(d);
                wait_done(n);
                chk("sweep_bin", 32'(bus.Bin), 32'(s));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
